// File: rtl/depth_test_unit.sv
`default_nettype none
// ============================================================================
// Module      : depth_test_unit
// Description : Single-clock z-buffer stage. Fragments arriving over
//               valid/ready are depth tested against an internal depth RAM.
//               Passing fragments update depth and issue a frame RAM write.
//               Provides a full-frame clear sweep, a selectable compare mode
//               (LEQUAL), same-address forwarding and out-of-range rejection.
//               Optional feature macro: DEPTH_STATS_EN (pass/reject counters).
// Revision    : 1.0 - initial release
// ============================================================================
module depth_test_unit #(
    parameter int                  WIDTH     = 320,
    parameter int                  HEIGHT    = 240,
    parameter int                  Z_BITS    = 16,
    parameter int                  RGB_BITS  = 12,
    parameter int                  LEQUAL    = 0,
    parameter logic [RGB_BITS-1:0] CLEAR_RGB = '0,
    localparam int                 X_BITS    = $clog2(WIDTH),
    localparam int                 Y_BITS    = $clog2(HEIGHT),
    localparam int                 A_BITS    = $clog2(WIDTH*HEIGHT)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                clear_in,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [X_BITS-1:0]   x_in,
    input  logic [Y_BITS-1:0]   y_in,
    input  logic [Z_BITS-1:0]   z_in,
    input  logic [RGB_BITS-1:0] rgb_in,
    output logic                fb_we_out,
    output logic [A_BITS-1:0]   fb_addr_out,
    output logic [RGB_BITS-1:0] fb_rgb_out,
    output logic                clearing_out
`ifdef DEPTH_STATS_EN
    ,
    output logic [31:0]         pass_count_out,
    output logic [31:0]         reject_count_out
`endif
);

    localparam int                c_PIXELS    = WIDTH * HEIGHT;
    localparam logic [A_BITS-1:0] c_LAST_ADDR = A_BITS'(c_PIXELS - 1);
    localparam logic [Z_BITS-1:0] c_Z_CLEAR   = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [A_BITS-1:0]   r_clr_addr;

    logic                r_s0_valid, r_s1_valid, r_s2_valid;
    logic                r_s0_clr,   r_s1_clr,   r_s2_clr;
    logic [A_BITS-1:0]   r_s0_addr,  r_s1_addr,  r_s2_addr;
    logic [Z_BITS-1:0]   r_s0_z,     r_s1_z,     r_s2_z;
    logic [RGB_BITS-1:0] r_s0_rgb,   r_s1_rgb,   r_s2_rgb;
    logic                r_s2_fwd;
    logic [Z_BITS-1:0]   r_s2_fwd_z;
    logic [Z_BITS-1:0]   r_ram_q;
    logic [Z_BITS-1:0]   r_mem [c_PIXELS];

    logic                w_accept;
    logic                w_in_range;
    logic                w_clr_start;
    logic                w_clr_inject;
    logic [A_BITS-1:0]   w_frag_addr;
    logic [Z_BITS-1:0]   w_stored;
    logic                w_pass;
    logic                w_ram_we;

    assign w_accept     = valid_in & ready_out;
    assign w_in_range   = ({1'b0, x_in} < (X_BITS+1)'(WIDTH)) &&
                          ({1'b0, y_in} < (Y_BITS+1)'(HEIGHT));
    assign w_clr_start  = (r_state == ST_IDLE) & clear_in;
    assign w_clr_inject = (r_state == ST_CLEAR);
    assign w_frag_addr  = A_BITS'(y_in) * A_BITS'(WIDTH) + A_BITS'(x_in);

    // Clear sequencer: IDLE accepts fragments, CLEAR injects one address per cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_clr_addr   <= '0;
            ready_out    <= 1'b1;
            clearing_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_in) begin
                        r_state      <= ST_CLEAR;
                        r_clr_addr   <= '0;
                        ready_out    <= 1'b0;
                        clearing_out <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_state      <= ST_IDLE;
                        ready_out    <= 1'b1;
                        clearing_out <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    ready_out    <= 1'b1;
                    clearing_out <= 1'b0;
                end
            endcase
        end
    end

    // S0: capture fragment (dropped if off-screen) or clear op, form linear address
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s0_valid <= 1'b0;
            r_s0_clr   <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_z     <= '0;
            r_s0_rgb   <= '0;
        end else begin
            r_s0_valid <= w_clr_inject | (w_accept & w_in_range);
            r_s0_clr   <= w_clr_inject;
            r_s0_addr  <= w_clr_inject ? r_clr_addr : w_frag_addr;
            r_s0_z     <= w_clr_inject ? c_Z_CLEAR  : z_in;
            r_s0_rgb   <= w_clr_inject ? CLEAR_RGB  : rgb_in;
        end
    end

    // S1: op waits here while the depth RAM read for its address is issued
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_clr   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_z     <= '0;
            r_s1_rgb   <= '0;
        end else begin
            r_s1_valid <= r_s0_valid;
            r_s1_clr   <= r_s0_clr;
            r_s1_addr  <= r_s0_addr;
            r_s1_z     <= r_s0_z;
            r_s1_rgb   <= r_s0_rgb;
        end
    end

    // Depth RAM: read-first, write from S2 on the same edge the output registers
    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            r_mem[r_s2_addr] <= r_s2_z;
        end
        r_ram_q <= r_mem[r_s1_addr];
    end

    // S2: load op; flag forwarding when the op ahead writes the address just read
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s2_valid <= 1'b0;
            r_s2_clr   <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_z     <= '0;
            r_s2_rgb   <= '0;
            r_s2_fwd   <= 1'b0;
            r_s2_fwd_z <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_clr   <= r_s1_clr;
            r_s2_addr  <= r_s1_addr;
            r_s2_z     <= r_s1_z;
            r_s2_rgb   <= r_s1_rgb;
            r_s2_fwd   <= w_ram_we & (r_s2_addr == r_s1_addr);
            r_s2_fwd_z <= r_s2_z;
        end
    end

    assign w_stored = r_s2_fwd ? r_s2_fwd_z : r_ram_q;

    generate
        if (LEQUAL != 0) begin : g_cmp_le
            assign w_pass = (r_s2_z <= w_stored);
        end else begin : g_cmp_lt
            assign w_pass = (r_s2_z < w_stored);
        end
    endgenerate

    // Clear ops write unconditionally; fragments only when the depth test passes
    assign w_ram_we = r_s2_valid & (r_s2_clr | w_pass);

    // Output register toward the frame RAM
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fb_we_out   <= 1'b0;
            fb_addr_out <= '0;
            fb_rgb_out  <= '0;
        end else begin
            fb_we_out <= w_ram_we;
            if (w_ram_we) begin
                fb_addr_out <= r_s2_addr;
                fb_rgb_out  <= r_s2_rgb;
            end
        end
    end

`ifdef DEPTH_STATS_EN
    // Fragment pass/reject counters, zeroed when a clear starts
    always_ff @(posedge clk_in) begin
        if (rst_in || w_clr_start) begin
            pass_count_out   <= '0;
            reject_count_out <= '0;
        end else if (r_s2_valid && !r_s2_clr) begin
            if (w_pass) begin
                pass_count_out <= pass_count_out + 32'd1;
            end else begin
                reject_count_out <= reject_count_out + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_depth_test_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_depth_test_unit
// Description : Self-checking bench for depth_test_unit. Two instances: the
//               full 320x240 strict-less build and a small 6x3 LEQUAL build.
//               A behavioural z-buffer model predicts every frame write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_depth_test_unit;

    localparam int          W0   = 320;
    localparam int          H0   = 240;
    localparam int          W1   = 6;
    localparam int          H1   = 3;
    localparam logic [11:0] CLR0 = 12'h3C7;
    localparam logic [11:0] CLR1 = 12'h5A5;
    localparam int          ZMAX = 65535;

    typedef struct {
        int addr;
        int rgb;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        d0_clear, d0_valid, d0_ready, d0_we, d0_clearing;
    logic [8:0]  d0_x;
    logic [7:0]  d0_y;
    logic [15:0] d0_z;
    logic [11:0] d0_rgb, d0_frgb;
    logic [16:0] d0_addr;
    logic        d1_clear, d1_valid, d1_ready, d1_we, d1_clearing;
    logic [2:0]  d1_x;
    logic [1:0]  d1_y;
    logic [15:0] d1_z;
    logic [11:0] d1_rgb, d1_frgb;
    logic [4:0]  d1_addr;
`ifdef DEPTH_STATS_EN
    logic [31:0] d0_pass, d0_rej, d1_pass, d1_rej;
`endif

    depth_test_unit #(.WIDTH(W0), .HEIGHT(H0), .Z_BITS(16), .RGB_BITS(12),
                      .LEQUAL(0), .CLEAR_RGB(CLR0)) u_dut (
        .clk_in(clk), .rst_in(rst), .clear_in(d0_clear), .valid_in(d0_valid),
        .ready_out(d0_ready), .x_in(d0_x), .y_in(d0_y), .z_in(d0_z),
        .rgb_in(d0_rgb), .fb_we_out(d0_we), .fb_addr_out(d0_addr),
        .fb_rgb_out(d0_frgb), .clearing_out(d0_clearing)
`ifdef DEPTH_STATS_EN
        , .pass_count_out(d0_pass), .reject_count_out(d0_rej)
`endif
    );

    depth_test_unit #(.WIDTH(W1), .HEIGHT(H1), .Z_BITS(16), .RGB_BITS(12),
                      .LEQUAL(1), .CLEAR_RGB(CLR1)) u_leq (
        .clk_in(clk), .rst_in(rst), .clear_in(d1_clear), .valid_in(d1_valid),
        .ready_out(d1_ready), .x_in(d1_x), .y_in(d1_y), .z_in(d1_z),
        .rgb_in(d1_rgb), .fb_we_out(d1_we), .fb_addr_out(d1_addr),
        .fb_rgb_out(d1_frgb), .clearing_out(d1_clearing)
`ifdef DEPTH_STATS_EN
        , .pass_count_out(d1_pass), .reject_count_out(d1_rej)
`endif
    );

    int  checks   = 0;
    int  failures = 0;
    wr_t obs0[$], obs1[$], exp0[$], exp1[$];
    int  ref0 [W0*H0];
    int  ref1 [W1*H1];
    wr_t mw0, mw1;

    // Frame-write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (d0_we === 1'b1) begin
            mw0.addr = int'(d0_addr); mw0.rgb = int'(d0_frgb); mw0.cyc = cyc;
            obs0.push_back(mw0);
        end
        if (d1_we === 1'b1) begin
            mw1.addr = int'(d1_addr); mw1.rgb = int'(d1_frgb); mw1.cyc = cyc;
            obs1.push_back(mw1);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Drive one fragment for a cycle; the z-buffer model predicts its write
    task automatic send(input int which, input int x, input int y, input int z, input int rgb);
        logic rdy;
        int   a;
        bit   ok;
        wr_t  e;
        if (which == 0) begin
            d0_valid = 1'b1; d0_x = 9'(x); d0_y = 8'(y); d0_z = 16'(z); d0_rgb = 12'(rgb);
            rdy = d0_ready;
            if (rdy && x < W0 && y < H0) begin
                a  = y * W0 + x;
                ok = z < ref0[a];
                if (ok) begin
                    ref0[a] = z;
                    e.addr = a; e.rgb = rgb; e.cyc = cyc + 4;
                    exp0.push_back(e);
                end
            end
        end else begin
            d1_valid = 1'b1; d1_x = 3'(x); d1_y = 2'(y); d1_z = 16'(z); d1_rgb = 12'(rgb);
            rdy = d1_ready;
            if (rdy && x < W1 && y < H1) begin
                a  = y * W1 + x;
                ok = z <= ref1[a];
                if (ok) begin
                    ref1[a] = z;
                    e.addr = a; e.rgb = rgb; e.cyc = cyc + 4;
                    exp1.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic flush_queues();
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d0_clear = 0; d0_valid = 0; d0_x = 0; d0_y = 0; d0_z = 0; d0_rgb = 0;
        d1_clear = 0; d1_valid = 0; d1_x = 0; d1_y = 0; d1_z = 0; d1_rgb = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({d0_ready, d0_we, d0_clearing, d0_addr, d0_frgb} !== {1'b1, 1'b0, 1'b0, 17'd0, 12'd0}) begin
            failures++;
            $display("FAIL reset_dut0: got ready=%b we=%b clr=%b addr=%0d rgb=%0h expected 1 0 0 0 0",
                     d0_ready, d0_we, d0_clearing, d0_addr, d0_frgb);
        end
        checks++;
        if ({d1_ready, d1_we, d1_clearing, d1_addr, d1_frgb} !== {1'b1, 1'b0, 1'b0, 5'd0, 12'd0}) begin
            failures++;
            $display("FAIL reset_dut1: got ready=%b we=%b clr=%b addr=%0d rgb=%0h expected 1 0 0 0 0",
                     d1_ready, d1_we, d1_clearing, d1_addr, d1_frgb);
        end
`ifdef DEPTH_STATS_EN
        checks++;
        if ({d0_pass, d0_rej, d1_pass, d1_rej} !== 128'd0) begin
            failures++;
            $display("FAIL reset_stats: got %0d %0d %0d %0d expected all 0", d0_pass, d0_rej, d1_pass, d1_rej);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        flush_queues();
    endtask

    task automatic test_clear();
        int c, n, bad;
        c = cyc;
        d0_clear = 1'b1; d1_clear = 1'b1;
        @(posedge clk); #1;
        d0_clear = 1'b0; d1_clear = 1'b0;
        checks++;
        if (d0_clearing !== 1'b1 || d0_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_start: got clearing=%b ready=%b expected 1 0", d0_clearing, d0_ready);
        end
        n = 0;
        while (d0_ready !== 1'b1 && n < 80000) begin
            n++;
            @(posedge clk); #1;
        end
        idle(6);
        checks++;
        if (n != W0 * H0) begin
            failures++;
            $display("FAIL clear_busy_cycles: got %0d expected %0d", n, W0 * H0);
        end
        checks++;
        if (d0_clearing !== 1'b0) begin
            failures++;
            $display("FAIL clear_end: got clearing=%b expected 0", d0_clearing);
        end
        checks++;
        bad = -1;
        for (int k = 0; k < obs0.size() && bad < 0; k++)
            if (obs0[k].addr != k || obs0[k].rgb != int'(CLR0) || obs0[k].cyc != c + 5 + k) bad = k;
        if (obs0.size() != W0 * H0 || bad >= 0) begin
            failures++;
            $display("FAIL clear_writes_dut0: got count=%0d first_bad=%0d expected count=%0d in-order addr/rgb/timing",
                     obs0.size(), bad, W0 * H0);
        end
        checks++;
        bad = -1;
        for (int k = 0; k < obs1.size() && bad < 0; k++)
            if (obs1[k].addr != k || obs1[k].rgb != int'(CLR1) || obs1[k].cyc != c + 5 + k) bad = k;
        if (obs1.size() != W1 * H1 || bad >= 0) begin
            failures++;
            $display("FAIL clear_writes_dut1: got count=%0d first_bad=%0d expected count=%0d",
                     obs1.size(), bad, W1 * H1);
        end
        foreach (ref0[i]) ref0[i] = ZMAX;
        foreach (ref1[i]) ref1[i] = ZMAX;
        flush_queues();
    endtask

    task automatic test_single();
        int c;
        c = cyc;
        send(0, 10, 2, 100, 'hABC);
        idle(1);
        send(0, 10, 2, 200, 'h123);
        idle(6);
        checks++;
        if (obs0.size() != 1) begin
            failures++;
            $display("FAIL single_count: got %0d expected 1", obs0.size());
        end else begin
            checks++;
            if (obs0[0].addr != 650 || obs0[0].rgb != 'hABC || obs0[0].cyc != c + 4) begin
                failures++;
                $display("FAIL single_write: got addr=%0d rgb=%0h cyc=%0d expected addr=650 rgb=abc cyc=%0d",
                         obs0[0].addr, obs0[0].rgb, obs0[0].cyc, c + 4);
            end
        end
        flush_queues();
    endtask

    task automatic test_back_to_back();
        int c;
        c = cyc;
        send(0, 5, 5, 50, 'h111);
        send(0, 5, 5, 40, 'h222);
        send(0, 5, 5, 45, 'h333);
        idle(6);
        checks++;
        if (obs0.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 2", obs0.size());
        end else begin
            checks++;
            if (obs0[0].addr != 1605 || obs0[0].rgb != 'h111 || obs0[0].cyc != c + 4 ||
                obs0[1].addr != 1605 || obs0[1].rgb != 'h222 || obs0[1].cyc != c + 5) begin
                failures++;
                $display("FAIL b2b_writes: got (%0d,%0h,%0d) (%0d,%0h,%0d) expected (1605,111,%0d) (1605,222,%0d)",
                         obs0[0].addr, obs0[0].rgb, obs0[0].cyc, obs0[1].addr, obs0[1].rgb, obs0[1].cyc, c + 4, c + 5);
            end
        end
        flush_queues();
    endtask

    task automatic test_compare_mode();
        send(0, 20, 3, 100, 'h001);
        idle(2);
        send(0, 20, 3, 100, 'h002);
        send(0, 320, 0, 0, 'h003);
        send(0, 0, 240, 0, 'h004);
        send(0, 511, 1, 0, 'h005);
        send(1, 2, 1, 100, 'h007);
        idle(2);
        send(1, 2, 1, 100, 'h008);
        send(1, 6, 0, 0, 'h009);
        send(1, 0, 3, 0, 'h00A);
        send(1, 7, 2, 0, 'h00B);
        idle(6);
        checks++;
        if (obs0.size() != 1 || (obs0.size() == 1 && (obs0[0].addr != 980 || obs0[0].rgb != 'h001))) begin
            failures++;
            $display("FAIL lt_equal_and_range: got count=%0d expected 1 write addr=980 rgb=001", obs0.size());
        end
        checks++;
        if (obs1.size() != 2 || (obs1.size() == 2 && (obs1[0].addr != 8 || obs1[0].rgb != 'h007 ||
                                                      obs1[1].addr != 8 || obs1[1].rgb != 'h008))) begin
            failures++;
            $display("FAIL le_equal_and_range: got count=%0d expected 2 writes addr=8 rgb=007,008", obs1.size());
        end
        flush_queues();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 7) == 0)
                send(0, $urandom_range(320, 511), $urandom_range(0, 239), $urandom_range(0, 63), $urandom_range(0, 4095));
            else
                send(0, 100 + $urandom_range(0, 3), 100 + $urandom_range(0, 2), $urandom_range(0, 63), $urandom_range(0, 4095));
        end
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 7) == 0)
                send(1, $urandom_range(0, 7), 3, $urandom_range(0, 63), $urandom_range(0, 4095));
            else
                send(1, $urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 63), $urandom_range(0, 4095));
        end
        idle(6);
        checks++;
        if (obs0.size() != exp0.size()) begin
            failures++;
            $display("FAIL rand0_count: got %0d expected %0d", obs0.size(), exp0.size());
        end else begin
            foreach (exp0[i]) begin
                checks++;
                if (obs0[i].addr != exp0[i].addr || obs0[i].rgb != exp0[i].rgb || obs0[i].cyc != exp0[i].cyc) begin
                    failures++;
                    $display("FAIL rand0_write[%0d]: got (%0d,%0h,%0d) expected (%0d,%0h,%0d)", i,
                             obs0[i].addr, obs0[i].rgb, obs0[i].cyc, exp0[i].addr, exp0[i].rgb, exp0[i].cyc);
                end
            end
        end
        checks++;
        if (obs1.size() != exp1.size()) begin
            failures++;
            $display("FAIL rand1_count: got %0d expected %0d", obs1.size(), exp1.size());
        end else begin
            foreach (exp1[i]) begin
                checks++;
                if (obs1[i].addr != exp1[i].addr || obs1[i].rgb != exp1[i].rgb || obs1[i].cyc != exp1[i].cyc) begin
                    failures++;
                    $display("FAIL rand1_write[%0d]: got (%0d,%0h,%0d) expected (%0d,%0h,%0d)", i,
                             obs1[i].addr, obs1[i].rgb, obs1[i].cyc, exp1[i].addr, exp1[i].rgb, exp1[i].cyc);
                end
            end
        end
        flush_queues();
    endtask

    task automatic test_clear_overlap();
        int c, n;
        c = cyc;
        d0_clear = 1'b1;
        send(0, 3, 0, 1, 'h9AB);
        d0_clear = 1'b0;
        idle(19);
        checks++;
        if (d0_ready !== 1'b0) begin
            failures++;
            $display("FAIL overlap_busy: got ready=%b expected 0", d0_ready);
        end
        checks++;
        if (obs0.size() < 2) begin
            failures++;
            $display("FAIL overlap_order: got %0d writes expected at least 2", obs0.size());
        end else if (obs0[0].addr != 3 || obs0[0].rgb != 'h9AB || obs0[0].cyc != c + 4 ||
                     obs0[1].addr != 0 || obs0[1].rgb != int'(CLR0) || obs0[1].cyc != c + 5) begin
            failures++;
            $display("FAIL overlap_order: got (%0d,%0h,%0d) (%0d,%0h,%0d) expected (3,9ab,%0d) (0,%0h,%0d)",
                     obs0[0].addr, obs0[0].rgb, obs0[0].cyc, obs0[1].addr, obs0[1].rgb, obs0[1].cyc,
                     c + 4, CLR0, c + 5);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (d0_ready !== 1'b1 || d0_clearing !== 1'b0 || d0_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got ready=%b clearing=%b we=%b expected 1 0 0", d0_ready, d0_clearing, d0_we);
        end
        n = obs0.size();
        idle(10);
        checks++;
        if (obs0.size() != n) begin
            failures++;
            $display("FAIL abort_writes: got %0d writes after reset expected 0", obs0.size() - n);
        end
        flush_queues();
    endtask

    task automatic test_stats();
        d1_clear = 1'b1;
        @(posedge clk); #1;
        d1_clear = 1'b0;
        idle(25);
        foreach (ref1[i]) ref1[i] = ZMAX;
        flush_queues();
        send(1, 0, 0, 10, 'h010);
        send(1, 1, 0, 20, 'h020);
        send(1, 0, 0, 11, 'h011);
        send(1, 1, 0, 30, 'h030);
        send(1, 2, 0, 5, 'h005);
        send(1, 7, 0, 0, 'h0FF);
        idle(6);
        checks++;
        if (obs1.size() != exp1.size() || exp1.size() != 3) begin
            failures++;
            $display("FAIL stats_writes: got %0d expected %0d (model) and 3", obs1.size(), exp1.size());
        end
`ifdef DEPTH_STATS_EN
        checks++;
        if (d1_pass !== 32'd3 || d1_rej !== 32'd2) begin
            failures++;
            $display("FAIL stats_counts: got pass=%0d reject=%0d expected pass=3 reject=2", d1_pass, d1_rej);
        end
        d1_clear = 1'b1;
        @(posedge clk); #1;
        d1_clear = 1'b0;
        checks++;
        if (d1_pass !== 32'd0 || d1_rej !== 32'd0) begin
            failures++;
            $display("FAIL stats_zero_on_clear: got pass=%0d reject=%0d expected 0 0", d1_pass, d1_rej);
        end
        idle(25);
        checks++;
        if (d1_pass !== 32'd0 || d1_rej !== 32'd0 || d1_ready !== 1'b1) begin
            failures++;
            $display("FAIL stats_after_clear: got pass=%0d reject=%0d ready=%b expected 0 0 1", d1_pass, d1_rej, d1_ready);
        end
`endif
        flush_queues();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single();
        test_back_to_back();
        test_compare_mode();
        test_random();
        test_clear_overlap();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
